// File: rtl/fft_reorder_pkg.sv
// rtl/fft_reorder_pkg.sv - shared sample types, FSM encodings and bit-reversal helper
package fft_reorder_pkg;

  localparam int FPT_W    = 32;
  localparam int FPT_FRAC = 16;

  // Fixed-point sample with 16 fractional bits; a complex sample is [1]=real, [0]=imag
  typedef logic signed [FPT_W-1:0] fpt;
  typedef fpt [1:0] cpx;

  typedef enum logic {W_IDLE, W_FILL} wr_state_t;
  typedef enum logic {R_IDLE, R_READ} rd_state_t;

  // Reverses the low n bits of idx; callers truncate to their own address width
  function automatic logic [31:0] bitrev(input int n, input logic [31:0] idx);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < n; i++) begin
      r[5'(i)] = idx[5'(n - 1 - i)];
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_reorder_bank.sv
// rtl/fft_reorder_bank.sv - L x 64-bit memory, one write port and one registered read port
module reorder_bank
  import fft_reorder_pkg::*;
#(
  parameter int N = 3
) (
  input  logic         clk,
  input  logic         we,
  input  logic [N-1:0] waddr,
  input  cpx           wdata,
  input  logic [N-1:0] raddr,
  output cpx           rdata
);

  cpx mem [1 << N];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/fft_reorder.sv
// rtl/fft_reorder.sv - ping-pong buffer turning bit-reversed FFT frames into natural order
module fft_reorder
  import fft_reorder_pkg::*;
#(
  parameter  int N = 3,
  localparam int L = 1 << N
) (
  input  logic     clk,
  input  logic     rst_n,
  input  fpt [1:0] ip,
  input  logic     start_ip,
  output fpt [1:0] op,
  output logic     start_op,
  output logic     valid_op
);

  localparam logic [N-1:0] LAST = N'(L - 1);

  wr_state_t    w_state, w_state_nxt;
  logic [N-1:0] wr_cnt, wr_cnt_nxt;
  logic         wr_bank, wr_bank_nxt;
  logic         we;
  logic [N-1:0] waddr;
  logic         frame_done;

  rd_state_t    r_state, r_state_nxt;
  logic [N-1:0] rd_cnt, rd_cnt_nxt;
  logic         rd_bank, rd_bank_nxt;
  logic [N-1:0] rd_addr;
  logic         q_bank;

  cpx           q0, q1;

  // A start pulse always restarts the fill at address 0 of the current bank
  always_comb begin
    w_state_nxt = w_state;
    wr_cnt_nxt  = wr_cnt;
    wr_bank_nxt = wr_bank;
    we          = 1'b0;
    waddr       = wr_cnt;
    frame_done  = 1'b0;
    if (start_ip) begin
      we          = 1'b1;
      waddr       = '0;
      wr_cnt_nxt  = N'(1);
      w_state_nxt = W_FILL;
    end else if (w_state == W_FILL) begin
      we         = 1'b1;
      wr_cnt_nxt = wr_cnt + N'(1);
      if (wr_cnt == LAST) begin
        wr_bank_nxt = ~wr_bank;
        frame_done  = 1'b1;
        w_state_nxt = W_IDLE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_state <= W_IDLE;
      wr_cnt  <= '0;
      wr_bank <= 1'b0;
    end else begin
      w_state <= w_state_nxt;
      wr_cnt  <= wr_cnt_nxt;
      wr_bank <= wr_bank_nxt;
    end
  end

  // frame_done wins over the end of a readout so back-to-back frames leave no gap
  always_comb begin
    r_state_nxt = r_state;
    rd_cnt_nxt  = rd_cnt;
    rd_bank_nxt = rd_bank;
    if (r_state == R_READ) begin
      rd_cnt_nxt = rd_cnt + N'(1);
      if (rd_cnt == LAST) begin
        r_state_nxt = R_IDLE;
      end
    end
    if (frame_done) begin
      r_state_nxt = R_READ;
      rd_cnt_nxt  = '0;
      rd_bank_nxt = wr_bank;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= R_IDLE;
      rd_cnt   <= '0;
      rd_bank  <= 1'b0;
      valid_op <= 1'b0;
      start_op <= 1'b0;
      q_bank   <= 1'b0;
    end else begin
      r_state  <= r_state_nxt;
      rd_cnt   <= rd_cnt_nxt;
      rd_bank  <= rd_bank_nxt;
      valid_op <= (r_state == R_READ);
      start_op <= (r_state == R_READ) && (rd_cnt == '0);
      q_bank   <= rd_bank;
    end
  end

  always_comb begin
    rd_addr = N'(bitrev(N, 32'(rd_cnt)));
  end

  reorder_bank #(.N(N)) u_bank0 (
    .clk   (clk),
    .we    (we && !wr_bank),
    .waddr (waddr),
    .wdata (ip),
    .raddr (rd_addr),
    .rdata (q0)
  );

  reorder_bank #(.N(N)) u_bank1 (
    .clk   (clk),
    .we    (we && wr_bank),
    .waddr (waddr),
    .wdata (ip),
    .raddr (rd_addr),
    .rdata (q1)
  );

  // Bank read data is already registered; gating with valid_op zeroes idle output
  always_comb begin
    op = '0;
    if (valid_op) begin
      op = q_bank ? q1 : q0;
    end
  end

endmodule

// File: tb/tb_fft_reorder.sv
// tb/tb_fft_reorder.sv - self-checking bench for fft_reorder against a frame-level model
module tb_fft_reorder;
  import fft_reorder_pkg::*;

  localparam int N     = 3;
  localparam int L     = 1 << N;
  localparam int T_MAX = 128;

  logic     clk = 1'b0;
  logic     rst_n = 1'b0;
  logic     start_ip = 1'b0;
  fpt [1:0] ip = '0;
  fpt [1:0] op;
  logic     start_op;
  logic     valid_op;

  int checks = 0;
  int errors = 0;

  bit s_rst   [T_MAX];
  bit s_start [T_MAX];
  fpt s_re    [T_MAX];
  fpt s_im    [T_MAX];

  logic o_valid [T_MAX];
  logic o_start [T_MAX];
  fpt   o_re    [T_MAX];
  fpt   o_im    [T_MAX];

  logic e_valid [T_MAX];
  logic e_start [T_MAX];
  fpt   e_re    [T_MAX];
  fpt   e_im    [T_MAX];

  int ord [8] = '{0, 4, 2, 6, 1, 5, 3, 7};

  fft_reorder #(.N(N)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .ip       (ip),
    .start_ip (start_ip),
    .op       (op),
    .start_op (start_op),
    .valid_op (valid_op)
  );

  always #5 clk = ~clk;

  function automatic int ref_rev(input int m);
    int r;
    r = 0;
    for (int i = 0; i < N; i++) begin
      if (((m >> i) & 1) == 1) r += 1 << (N - 1 - i);
    end
    return r;
  endfunction

  task automatic clear_stim();
    for (int c = 0; c < T_MAX; c++) begin
      s_rst[c]   = (c >= 2);
      s_start[c] = 1'b0;
      s_re[c]    = fpt'($urandom);
      s_im[c]    = fpt'($urandom);
    end
  endtask

  task automatic put_ramp(input int t0, input int base);
    s_start[t0] = 1'b1;
    for (int k = 0; k < L; k++) begin
      if (t0 + k < T_MAX) begin
        s_re[t0 + k] = fpt'((base + k) * 65536);
        s_im[t0 + k] = fpt'(-(base + k) * 65536);
      end
    end
  endtask

  // Frame-level model: a start survives if no restart or reset follows within L cycles;
  // its sample bitrev(m) appears at t0+L+1+m unless reset has been seen since t0
  task automatic build_expected(input int T);
    bit ok;
    bit alive;
    int k;
    for (int c = 0; c < T; c++) begin
      e_valid[c] = 1'b0;
      e_start[c] = 1'b0;
      e_re[c]    = '0;
      e_im[c]    = '0;
    end
    for (int t0 = 0; t0 < T; t0++) begin
      if (!(s_start[t0] && s_rst[t0])) continue;
      ok = 1'b1;
      for (int j = 1; j < L; j++) begin
        if (t0 + j >= T || s_start[t0 + j] || !s_rst[t0 + j]) ok = 1'b0;
      end
      if (!ok) continue;
      alive = 1'b1;
      for (int m = 0; m < L; m++) begin
        k = t0 + L + 1 + m;
        if (k >= T) break;
        for (int c = t0 + L; c <= k; c++) begin
          if (!s_rst[c]) alive = 1'b0;
        end
        if (!alive) break;
        e_valid[k] = 1'b1;
        e_start[k] = (m == 0);
        e_re[k]    = s_re[t0 + ref_rev(m)];
        e_im[k]    = s_im[t0 + ref_rev(m)];
      end
    end
  endtask

  task automatic run_stream(input int T);
    for (int c = 0; c < T; c++) begin
      rst_n    = s_rst[c];
      start_ip = s_start[c];
      ip[1]    = s_re[c];
      ip[0]    = s_im[c];
      @(negedge clk);
      o_valid[c] = valid_op;
      o_start[c] = start_op;
      o_re[c]    = op[1];
      o_im[c]    = op[0];
      @(posedge clk);
      #1;
    end
    start_ip = 1'b0;
    build_expected(T);
  endtask

  task automatic test_reset();
    clear_stim();
    for (int c = 0; c < 12; c++) begin
      s_rst[c]   = 1'b0;
      s_start[c] = $urandom_range(0, 1);
    end
    run_stream(12);
    for (int c = 0; c < 12; c++) begin
      checks++;
      if (o_valid[c] !== 1'b0 || o_start[c] !== 1'b0 || o_re[c] !== '0 || o_im[c] !== '0) begin
        errors++;
        $display("FAIL reset cycle %0d: got v=%b s=%b op=%h/%h, want all zero",
                 c, o_valid[c], o_start[c], o_re[c], o_im[c]);
      end
    end
  endtask

  task automatic test_single_frame();
    int nvalid;
    clear_stim();
    put_ramp(4, 0);
    run_stream(24);
    nvalid = 0;
    for (int c = 0; c < 24; c++) begin
      nvalid += int'(o_valid[c] === 1'b1);
      checks++;
      if (o_valid[c] !== e_valid[c] || o_start[c] !== e_start[c] || o_re[c] !== e_re[c] || o_im[c] !== e_im[c]) begin
        errors++;
        $display("FAIL single_frame cycle %0d: got v=%b s=%b op=%h/%h, want v=%b s=%b op=%h/%h",
                 c, o_valid[c], o_start[c], o_re[c], o_im[c], e_valid[c], e_start[c], e_re[c], e_im[c]);
      end
    end
    for (int m = 0; m < L; m++) begin
      checks++;
      if (o_re[4 + L + 1 + m] !== fpt'(ord[m] * 65536) || o_im[4 + L + 1 + m] !== fpt'(-ord[m] * 65536)) begin
        errors++;
        $display("FAIL single_frame_order m=%0d: got %h/%h, want %h/%h", m,
                 o_re[4 + L + 1 + m], o_im[4 + L + 1 + m], fpt'(ord[m] * 65536), fpt'(-ord[m] * 65536));
      end
    end
    checks++;
    if (nvalid != L || o_start[4 + L + 1] !== 1'b1) begin
      errors++;
      $display("FAIL single_frame_span: got valid count %0d start@t0+9=%b, want %0d and 1",
               nvalid, o_start[4 + L + 1], L);
    end
  endtask

  task automatic test_back_to_back();
    int nvalid;
    clear_stim();
    put_ramp(4, 0);
    put_ramp(4 + L, 8);
    run_stream(32);
    nvalid = 0;
    for (int c = 0; c < 32; c++) begin
      checks++;
      if (o_valid[c] !== e_valid[c] || o_start[c] !== e_start[c] || o_re[c] !== e_re[c] || o_im[c] !== e_im[c]) begin
        errors++;
        $display("FAIL back_to_back cycle %0d: got v=%b s=%b op=%h/%h, want v=%b s=%b op=%h/%h",
                 c, o_valid[c], o_start[c], o_re[c], o_im[c], e_valid[c], e_start[c], e_re[c], e_im[c]);
      end
    end
    for (int c = 4 + L + 1; c < 4 + 3 * L + 1; c++) nvalid += int'(o_valid[c] === 1'b1);
    checks++;
    if (nvalid != 2 * L || o_start[4 + L + 1] !== 1'b1 || o_start[4 + 2 * L + 1] !== 1'b1) begin
      errors++;
      $display("FAIL back_to_back_run: got run %0d starts %b/%b, want %0d and 1/1",
               nvalid, o_start[4 + L + 1], o_start[4 + 2 * L + 1], 2 * L);
    end
    checks++;
    if (o_re[4 + 2 * L + 2] !== fpt'(12 * 65536)) begin
      errors++;
      $display("FAIL back_to_back_second: got %h, want %h", o_re[4 + 2 * L + 2], fpt'(12 * 65536));
    end
  endtask

  task automatic test_restart();
    clear_stim();
    put_ramp(4, 0);
    put_ramp(7, 20);
    run_stream(28);
    for (int c = 0; c < 28; c++) begin
      checks++;
      if (o_valid[c] !== e_valid[c] || o_start[c] !== e_start[c] || o_re[c] !== e_re[c] || o_im[c] !== e_im[c]) begin
        errors++;
        $display("FAIL restart cycle %0d: got v=%b s=%b op=%h/%h, want v=%b s=%b op=%h/%h",
                 c, o_valid[c], o_start[c], o_re[c], o_im[c], e_valid[c], e_start[c], e_re[c], e_im[c]);
      end
    end
    checks++;
    if (o_start[7 + L + 1] !== 1'b1 || o_valid[7 + L] !== 1'b0 || o_re[7 + L + 2] !== fpt'(24 * 65536)) begin
      errors++;
      $display("FAIL restart_frame: got start=%b prev_valid=%b op1=%h, want 1 0 %h",
               o_start[7 + L + 1], o_valid[7 + L], o_re[7 + L + 2], fpt'(24 * 65536));
    end
  endtask

  task automatic test_idle_gap();
    int nvalid;
    clear_stim();
    put_ramp(4, 0);
    s_start[20] = 1'b1;
    run_stream(40);
    nvalid = 0;
    for (int c = 0; c < 40; c++) begin
      nvalid += int'(o_valid[c] === 1'b1);
      checks++;
      if (o_valid[c] !== e_valid[c] || o_start[c] !== e_start[c] || o_re[c] !== e_re[c] || o_im[c] !== e_im[c]) begin
        errors++;
        $display("FAIL idle_gap cycle %0d: got v=%b s=%b op=%h/%h, want v=%b s=%b op=%h/%h",
                 c, o_valid[c], o_start[c], o_re[c], o_im[c], e_valid[c], e_start[c], e_re[c], e_im[c]);
      end
    end
    checks++;
    if (nvalid != 2 * L) begin
      errors++;
      $display("FAIL idle_gap_count: got %0d valid cycles, want %0d", nvalid, 2 * L);
    end
  endtask

  task automatic test_async_reset();
    clear_stim();
    put_ramp(4, 0);
    s_rst[16] = 1'b0;
    s_rst[17] = 1'b0;
    s_start[20] = 1'b1;
    run_stream(40);
    for (int c = 0; c < 40; c++) begin
      checks++;
      if (o_valid[c] !== e_valid[c] || o_start[c] !== e_start[c] || o_re[c] !== e_re[c] || o_im[c] !== e_im[c]) begin
        errors++;
        $display("FAIL async_reset cycle %0d: got v=%b s=%b op=%h/%h, want v=%b s=%b op=%h/%h",
                 c, o_valid[c], o_start[c], o_re[c], o_im[c], e_valid[c], e_start[c], e_re[c], e_im[c]);
      end
    end
    checks++;
    if (o_valid[15] !== 1'b1 || o_valid[16] !== 1'b0 || o_re[16] !== '0 || o_valid[18] !== 1'b0) begin
      errors++;
      $display("FAIL async_reset_kill: got v15=%b v16=%b op16=%h v18=%b, want 1 0 0 0",
               o_valid[15], o_valid[16], o_re[16], o_valid[18]);
    end
  endtask

  task automatic test_random();
    int t;
    for (int iter = 0; iter < 4; iter++) begin
      clear_stim();
      t = 3;
      while (t + 2 * L + 2 < T_MAX) begin
        s_start[t] = 1'b1;
        if ($urandom_range(0, 3) == 0) begin
          t += $urandom_range(1, L - 1);
          s_start[t] = 1'b1;
        end
        if ($urandom_range(0, 7) == 0) s_rst[t + $urandom_range(1, 2 * L)] = 1'b0;
        t += L + $urandom_range(0, 5);
      end
      run_stream(T_MAX);
      for (int c = 0; c < T_MAX; c++) begin
        checks++;
        if (o_valid[c] !== e_valid[c] || o_start[c] !== e_start[c] || o_re[c] !== e_re[c] || o_im[c] !== e_im[c]) begin
          errors++;
          $display("FAIL random%0d cycle %0d: got v=%b s=%b op=%h/%h, want v=%b s=%b op=%h/%h",
                   iter, c, o_valid[c], o_start[c], o_re[c], o_im[c], e_valid[c], e_start[c], e_re[c], e_im[c]);
        end
      end
    end
  endtask

  initial begin
    @(posedge clk);
    #1;
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_restart();
    test_idle_gap();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
